// File: rtl/neuron_sum_collector.sv
// Collects per-neuron sums into one packed layer vector; optional saturation via NEURON_SUM_SATURATE_EN.
// Latency: outputs_valid rises one cycle after the transfer that fills the last slot of the layer.
// Backpressure: the vector is held stable until outputs_ready; no sums or sizes are accepted meanwhile.
module neuron_sum_collector #(
    parameter int NEURON_NUM          = 5,
    parameter int NEURON_OUTPUT_WIDTH = 10
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [$clog2(NEURON_NUM):0]               layer_size,
    input  logic                                      layer_size_valid,
    output logic                                      layer_size_ready,
    input  logic [NEURON_OUTPUT_WIDTH-1:0]            neuron_sum,
    input  logic                                      overflow,
    input  logic                                      neuron_sum_valid,
    output logic                                      neuron_sum_ready,
    output logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] outputs,
    output logic [NEURON_NUM-1:0]                     outputs_overflow,
    output logic                                      outputs_valid,
    input  logic                                      outputs_ready
);

    localparam int LW = $clog2(NEURON_NUM) + 1;
    localparam int CW = $clog2(NEURON_NUM + 1);
    localparam int W  = NEURON_OUTPUT_WIDTH;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] OUTPUT  = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] slot;
    logic [CW-1:0] target;
    logic [CW-1:0] eff_size;
    logic [W-1:0]  sum_store;
    logic          last_slot;

    assign layer_size_ready = (state == IDLE);
    assign neuron_sum_ready = (state == COLLECT);
    assign outputs_valid    = (state == OUTPUT);

    // Out-of-range sizes (0 or above capacity) mean "fill every slot".
    always_comb begin
        eff_size = CW'(NEURON_NUM);
        if (layer_size != '0 && layer_size <= LW'(NEURON_NUM))
            eff_size = CW'(layer_size);
    end

`ifdef NEURON_SUM_SATURATE_EN
    assign sum_store = overflow ? {1'b0, {(W-1){1'b1}}} : neuron_sum;
`else
    assign sum_store = neuron_sum;
`endif

    assign last_slot = (slot == target - CW'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            slot             <= '0;
            target           <= '0;
            outputs          <= '0;
            outputs_overflow <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (layer_size_valid) begin
                        target <= eff_size;
                        slot   <= '0;
                        state  <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (neuron_sum_valid) begin
                        for (int i = 0; i < NEURON_NUM; i++) begin
                            if (slot == CW'(i)) begin
                                outputs[i*W +: W]   <= sum_store;
                                outputs_overflow[i] <= overflow;
                            end
                        end
                        slot <= slot + CW'(1);
                        if (last_slot)
                            state <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    // Clearing on hand-off keeps unused slots at zero for the next layer.
                    if (outputs_ready) begin
                        outputs          <= '0;
                        outputs_overflow <= '0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
